// File: rtl/bram_fifo_ctrl_8.sv
// Byte FIFO controller around a 2k x 8 dual-port RAM with a 2-entry output skid buffer.
// Optional sticky error flags err_ovf/err_unf are compiled in with FIFO_ERR_FLAGS_EN.
module bram_fifo_ctrl_8 #(
    parameter int ADDR_W       = 11,
    parameter int DATA_W       = 8,
    parameter int AFULL_THRESH = 1920
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_a,
    output logic [DATA_W-1:0] bram_di,
    output logic [ADDR_W-1:0] bram_dpra,
    input  logic [DATA_W-1:0] bram_dpo,
    output logic              almost_full,
    output logic              empty
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic              err_ovf,
    output logic              err_unf
`endif
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] AFULL = (ADDR_W+1)'(AFULL_THRESH);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   ram_count;
    logic              rd_pend;
    logic [1:0]        buf_count;
    logic [DATA_W-1:0] buf0;
    logic [DATA_W-1:0] buf1;
    logic              wr_en;
    logic              rd_en;
    logic              pop;
    logic [2:0]        buf_proj;

    assign in_ready    = ~reset & (ram_count < DEPTH);
    assign wr_en       = in_valid & in_ready;
    assign bram_we     = wr_en;
    assign bram_a      = wr_ptr;
    assign bram_di     = in_data;
    assign bram_dpra   = rd_ptr;

    assign out_valid   = (buf_count != 2'd0);
    assign out_data    = buf0;
    assign pop         = out_valid & out_ready;
    assign almost_full = (ram_count >= AFULL);
    assign empty       = (ram_count == '0) & ~rd_pend & (buf_count == 2'd0);

    // Occupancy the buffer will have once the in-flight read lands; never issue past 2.
    assign buf_proj = {1'b0, buf_count} + {2'b00, rd_pend} - {2'b00, pop};
    assign rd_en    = (ram_count != '0) & (buf_proj <= 3'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_count <= '0;
            rd_pend   <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            rd_pend <= rd_en;
            case ({wr_en, rd_en})
                2'b10:   ram_count <= ram_count + 1'b1;
                2'b01:   ram_count <= ram_count - 1'b1;
                default: ram_count <= ram_count;
            endcase
        end
    end

    // RAM read data arrives one cycle after issue and is pushed straight into the buffer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_count <= 2'd0;
            buf0      <= '0;
            buf1      <= '0;
        end else begin
            case ({rd_pend, pop})
                2'b10: begin
                    if (buf_count == 2'd0) buf0 <= bram_dpo;
                    else                   buf1 <= bram_dpo;
                    buf_count <= buf_count + 2'd1;
                end
                2'b01: begin
                    buf0      <= buf1;
                    buf_count <= buf_count - 2'd1;
                end
                2'b11: begin
                    if (buf_count == 2'd1) begin
                        buf0 <= bram_dpo;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= bram_dpo;
                    end
                end
                default: buf_count <= buf_count;
            endcase
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else begin
            if (in_valid & ~in_ready)           err_ovf <= 1'b1;
            if (out_ready & ~out_valid & empty) err_unf <= 1'b1;
        end
    end
`endif

endmodule
